// File: rtl/fft_out_reorder_pkg.sv
// rtl/fft_out_reorder_pkg.sv - shared constants, sample type and bit-reverse helper for the FFT output reorder
package fft_reorder_pkg;

    localparam int BW    = 16;
    localparam int N     = 64;
    localparam int LOG2N = 6;
    localparam int HALF  = N / 2;

    typedef struct packed {
        logic [BW-1:0] re;
        logic [BW-1:0] im;
    } cplx_t;

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - pair input stream and natural-order sample output stream of the reorder
interface fft_out_reorder_if;
    import fft_reorder_pkg::*;

    logic             in_valid;
    logic             in_sop;
    logic [BW-1:0]    inReal0;
    logic [BW-1:0]    inImag0;
    logic [BW-1:0]    inReal1;
    logic [BW-1:0]    inImag1;
    logic             in_ready;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    outReal;
    logic [BW-1:0]    outImag;
    logic [LOG2N-1:0] out_index;
    logic             out_sop;
    logic             out_eop;

    modport slave (
        input  in_valid, in_sop, inReal0, inImag0, inReal1, inImag1, out_ready,
        output in_ready, overflow, out_valid, outReal, outImag, out_index, out_sop, out_eop
    );

    modport master (
        output in_valid, in_sop, inReal0, inImag0, inReal1, inImag1, out_ready,
        input  in_ready, overflow, out_valid, outReal, outImag, out_index, out_sop, out_eop
    );

endinterface

// File: rtl/fft_out_reorder_bank.sv
// rtl/fft_out_reorder_bank.sv - one 64-entry frame store: two half write ports sharing an address, one combinational read
module reorder_bank
    import fft_reorder_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [4:0] waddr_i,
    input  cplx_t      wdata0_i,
    input  cplx_t      wdata1_i,
    input  logic [5:0] raddr_i,
    output cplx_t      rdata_o
);

    cplx_t mem0_q [HALF];
    cplx_t mem1_q [HALF];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem0_q[waddr_i] <= wdata0_i;
            mem1_q[waddr_i] <= wdata1_i;
        end
    end

    // Half 1 holds natural indices 32..63.
    assign rdata_o = raddr_i[5] ? mem1_q[raddr_i[4:0]] : mem0_q[raddr_i[4:0]];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong bit-reversed to natural order reorder; FFT_REORDER_OVF_EN adds sticky overflow and ovf_cnt
module fft_out_reorder
    import fft_reorder_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    fft_out_reorder_if.slave  io
`ifdef FFT_REORDER_OVF_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    logic       wr_buf_q, wr_buf_d;
    logic [4:0] wr_cnt_q, wr_cnt_d;
    logic       rd_buf_q, rd_buf_d;
    logic [5:0] rd_cnt_q, rd_cnt_d;
    logic [1:0] buf_full_q, buf_full_d;

    logic       out_valid_q, out_valid_d;
    cplx_t      out_data_q, out_data_d;
    logic [5:0] out_index_q, out_index_d;
    logic       out_sop_q, out_sop_d;
    logic       out_eop_q, out_eop_d;

    logic       in_ready;
    logic       wr_acc;
    logic [4:0] wr_k;
    logic       wr_last;
    logic       rd_load;
    logic       rd_last;
    logic       drop;
    cplx_t      wdata0, wdata1;
    cplx_t      rdata0, rdata1, rdata;

    assign in_ready = !buf_full_q[wr_buf_q];
    assign wr_acc   = io.in_valid && in_ready;
    assign drop     = io.in_valid && !in_ready;
    // in_sop restarts the frame, abandoning any partial fill in this buffer.
    assign wr_k     = io.in_sop ? 5'd0 : wr_cnt_q;
    assign wr_last  = wr_acc && (wr_k == 5'd31);
    assign rd_load  = buf_full_q[rd_buf_q] && (!out_valid_q || io.out_ready);
    assign rd_last  = rd_load && (rd_cnt_q == 6'd63);

    assign wdata0 = '{re: io.inReal0, im: io.inImag0};
    assign wdata1 = '{re: io.inReal1, im: io.inImag1};

    reorder_bank u_bank0 (
        .clk      (clk),
        .we_i     (wr_acc && !wr_buf_q),
        .waddr_i  (bitrev5(wr_k)),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .raddr_i  (rd_cnt_q),
        .rdata_o  (rdata0)
    );

    reorder_bank u_bank1 (
        .clk      (clk),
        .we_i     (wr_acc && wr_buf_q),
        .waddr_i  (bitrev5(wr_k)),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .raddr_i  (rd_cnt_q),
        .rdata_o  (rdata1)
    );

    assign rdata = rd_buf_q ? rdata1 : rdata0;

    always_comb begin
        wr_buf_d    = wr_buf_q;
        wr_cnt_d    = wr_cnt_q;
        rd_buf_d    = rd_buf_q;
        rd_cnt_d    = rd_cnt_q;
        buf_full_d  = buf_full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;

        if (wr_acc) begin
            wr_cnt_d = wr_k + 5'd1;
            if (wr_last) begin
                wr_buf_d = !wr_buf_q;
                wr_cnt_d = 5'd0;
            end
        end

        if (rd_load) begin
            out_valid_d = 1'b1;
            out_data_d  = rdata;
            out_index_d = rd_cnt_q;
            out_sop_d   = (rd_cnt_q == 6'd0);
            out_eop_d   = (rd_cnt_q == 6'd63);
            rd_cnt_d    = rd_cnt_q + 6'd1;
            if (rd_last) begin
                rd_buf_d = !rd_buf_q;
                rd_cnt_d = 6'd0;
            end
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Set and clear in the same cycle always hit different buffers.
        if (rd_last) buf_full_d[rd_buf_q] = 1'b0;
        if (wr_last) buf_full_d[wr_buf_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_buf_q    <= 1'b0;
            wr_cnt_q    <= 5'd0;
            rd_buf_q    <= 1'b0;
            rd_cnt_q    <= 6'd0;
            buf_full_q  <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= 6'd0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            wr_buf_q    <= wr_buf_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_buf_q    <= rd_buf_d;
            rd_cnt_q    <= rd_cnt_d;
            buf_full_q  <= buf_full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

`ifdef FFT_REORDER_OVF_EN
    logic        overflow_q, overflow_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        overflow_d = overflow_q | drop;
        ovf_cnt_d  = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overflow_q <= 1'b0;
            ovf_cnt_q  <= 16'd0;
        end else begin
            overflow_q <= overflow_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign io.overflow = overflow_q;
    assign ovf_cnt     = ovf_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign io.overflow = 1'b0;
`endif

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.outReal   = out_data_q.re;
    assign io.outImag   = out_data_q.im;
    assign io.out_index = out_index_q;
    assign io.out_sop   = out_sop_q;
    assign io.out_eop   = out_eop_q;

endmodule
